// File: rtl/i2c_slave_target.sv
// rtl/i2c_slave_target.sv - I2C target endpoint bridging bus transfers to a local 8-bit register bank
module i2c_slave_target #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         NUM_REGS   = 16,
  parameter int         REG_AW     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  output logic              reg_wr_en,
  output logic [REG_AW-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_rd_req,
  input  logic [7:0]        reg_rdata,
  output logic              busy,
  output logic              stop_det
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;

  localparam logic [8:0]        NUM_REGS_W = 9'(NUM_REGS);
  localparam logic [REG_AW-1:0] PTR_LAST   = REG_AW'(NUM_REGS - 1);

  state_t      state;
  logic        scl_s1, scl_s2, scl_d;
  logic        sda_s1, sda_s2, sda_d;
  logic [3:0]  bit_cnt;
  logic [7:0]  rx_shift;
  logic [7:0]  tx_shift;
  logic        rw;
  logic        rd_go;
  logic        rd_latch;

  logic             scl_rise, scl_fall, start_cond, stop_cond;
  logic [7:0]       rx_next;
  logic [REG_AW-1:0] ptr_next;

  assign scl_rise   = scl_s2 & ~scl_d;
  assign scl_fall   = ~scl_s2 & scl_d;
  assign start_cond = scl_s2 & scl_d & sda_d & ~sda_s2;
  assign stop_cond  = scl_s2 & scl_d & ~sda_d & sda_s2;
  assign rx_next    = {rx_shift[6:0], sda_s2};
  assign ptr_next   = (reg_addr == PTR_LAST) ? '0 : reg_addr + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      scl_s1     <= 1'b1;
      scl_s2     <= 1'b1;
      scl_d      <= 1'b1;
      sda_s1     <= 1'b1;
      sda_s2     <= 1'b1;
      sda_d      <= 1'b1;
      bit_cnt    <= '0;
      rx_shift   <= '0;
      tx_shift   <= '0;
      rw         <= 1'b0;
      rd_go      <= 1'b0;
      rd_latch   <= 1'b0;
      sda_oe     <= 1'b0;
      reg_wr_en  <= 1'b0;
      reg_addr   <= '0;
      reg_wdata  <= '0;
      reg_rd_req <= 1'b0;
      busy       <= 1'b0;
      stop_det   <= 1'b0;
    end else begin
      scl_s1     <= scl_in;
      scl_s2     <= scl_s1;
      scl_d      <= scl_s2;
      sda_s1     <= sda_in;
      sda_s2     <= sda_s1;
      sda_d      <= sda_s2;
      reg_wr_en  <= 1'b0;
      stop_det   <= 1'b0;
      // Read pipeline: request one cycle after rd_go, capture rdata the cycle after the request
      reg_rd_req <= rd_go;
      rd_go      <= 1'b0;
      rd_latch   <= reg_rd_req;
      if (rd_latch) tx_shift <= reg_rdata;

      if (stop_cond) begin
        state    <= IDLE;
        busy     <= 1'b0;
        stop_det <= 1'b1;
        sda_oe   <= 1'b0;
        bit_cnt  <= '0;
      end else if (start_cond) begin
        state   <= ADDR;
        busy    <= 1'b1;
        sda_oe  <= 1'b0;
        bit_cnt <= '0;
      end else begin
        case (state)
          ADDR, REG, WDATA: begin
            if (scl_rise && bit_cnt != 4'd8) begin
              rx_shift <= rx_next;
              bit_cnt  <= bit_cnt + 1'b1;
              if (bit_cnt == 4'd7) begin
                if (state == ADDR) begin
                  rw <= sda_s2;
                  if (rx_next[7:1] != SLAVE_ADDR) state <= IGNORE;
                end else if (state == REG) begin
                  if ({1'b0, rx_next} < NUM_REGS_W) reg_addr <= rx_next[REG_AW-1:0];
                  else state <= IGNORE;
                end else begin
                  reg_wr_en <= 1'b1;
                  reg_wdata <= rx_next;
                end
              end
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= '0;
              sda_oe  <= 1'b1;
              if (state == ADDR) begin
                state <= ADDR_ACK;
                rd_go <= rw;
              end else if (state == REG) begin
                state <= REG_ACK;
              end else begin
                state <= WDATA_ACK;
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              if (rw) begin
                state    <= RDATA;
                sda_oe   <= ~tx_shift[7];
                tx_shift <= {tx_shift[6:0], 1'b0};
                bit_cnt  <= 4'd1;
              end else begin
                state   <= REG;
                sda_oe  <= 1'b0;
                bit_cnt <= '0;
              end
            end
          end
          REG_ACK, WDATA_ACK: begin
            if (scl_fall) begin
              state  <= WDATA;
              sda_oe <= 1'b0;
              if (state == WDATA_ACK) reg_addr <= ptr_next;
            end
          end
          RDATA: begin
            if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                state   <= RDATA_ACK;
                sda_oe  <= 1'b0;
                bit_cnt <= '0;
              end else begin
                sda_oe   <= ~tx_shift[7];
                tx_shift <= {tx_shift[6:0], 1'b0};
                bit_cnt  <= bit_cnt + 1'b1;
              end
            end
          end
          RDATA_ACK: begin
            // bit_cnt = 1 marks that the master acknowledged and another byte follows
            if (scl_rise) begin
              if (!sda_s2) begin
                reg_addr <= ptr_next;
                rd_go    <= 1'b1;
                bit_cnt  <= 4'd1;
              end else begin
                state <= IGNORE;
              end
            end else if (scl_fall && bit_cnt == 4'd1) begin
              state    <= RDATA;
              sda_oe   <= ~tx_shift[7];
              tx_shift <= {tx_shift[6:0], 1'b0};
            end
          end
          default: sda_oe <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_target.sv
// tb/tb_i2c_slave_target.sv - directed bus-master bench for i2c_slave_target
module tb_i2c_slave_target;

  localparam int Q = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_bus;
  logic       sda_oe;
  logic       reg_wr_en;
  logic [3:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_rd_req;
  logic [7:0] reg_rdata = 8'h00;
  logic       busy;
  logic       stop_det;

  int n_checks = 0;
  int n_fail = 0;
  int stop_cnt = 0;
  int oe_cnt = 0;
  int rd_idx = 0;
  logic [3:0] wr_addr_q[$];
  logic [7:0] wr_data_q[$];
  logic [3:0] rd_addr_q[$];
  logic [7:0] rd_tbl [0:3];

  assign sda_bus = m_sda & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave_target #(.SLAVE_ADDR(7'h50), .NUM_REGS(16), .REG_AW(4)) dut (
    .clk(clk), .reset(reset), .scl_in(m_scl), .sda_in(sda_bus), .sda_oe(sda_oe),
    .reg_wr_en(reg_wr_en), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_rd_req(reg_rd_req), .reg_rdata(reg_rdata), .busy(busy), .stop_det(stop_det)
  );

  always @(negedge clk) begin
    if (reg_wr_en) begin
      wr_addr_q.push_back(reg_addr);
      wr_data_q.push_back(reg_wdata);
    end
    if (reg_rd_req) begin
      rd_addr_q.push_back(reg_addr);
      reg_rdata = rd_tbl[rd_idx % 4];
      rd_idx++;
    end
    if (stop_det) stop_cnt++;
    if (sda_oe) oe_cnt++;
  end

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; wait_q();
    m_scl = 1'b1; wait_q();
    m_sda = 1'b0; wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wait_q();
    m_scl = 1'b1; wait_q();
    m_sda = 1'b1; wait_q();
  endtask

  task automatic send_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      m_sda = b[i]; wait_q();
      m_scl = 1'b1; wait_q(); wait_q();
      m_scl = 1'b0; wait_q();
    end
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    send_bits(b);
    m_sda = 1'b1; wait_q();
    m_scl = 1'b1; wait_q();
    ack = sda_bus; wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b);
    m_sda = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      wait_q();
      m_scl = 1'b1; wait_q();
      b[i] = sda_bus; wait_q();
      m_scl = 1'b0; wait_q();
    end
    m_sda = mack; wait_q();
    m_scl = 1'b1; wait_q(); wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic clear_logs();
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_addr_q.delete();
    stop_cnt = 0;
    oe_cnt = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if ({sda_oe, reg_wr_en, reg_rd_req, busy, stop_det} !== 5'b0) begin
      n_fail++; $display("FAIL reset_strobes: got %b expected 00000", {sda_oe, reg_wr_en, reg_rd_req, busy, stop_det});
    end
    n_checks++;
    if (reg_addr !== 4'h0 || reg_wdata !== 8'h00) begin
      n_fail++; $display("FAIL reset_regs: got addr %h wdata %h expected 0 00", reg_addr, reg_wdata);
    end
    reset = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || stop_det !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset: got busy %b stop %b expected 0 0", busy, stop_det);
    end
  endtask

  task automatic test_write();
    logic a0, a1, a2;
    clear_logs();
    i2c_start();
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL write_busy: got %b expected 1", busy); end
    write_byte(8'hA0, a0);
    write_byte(8'h03, a1);
    write_byte(8'h5A, a2);
    n_checks++;
    if ({a0, a1, a2} !== 3'b000) begin n_fail++; $display("FAIL write_acks: got %b expected 000", {a0, a1, a2}); end
    i2c_stop();
    wait_q();
    n_checks++;
    if (busy !== 1'b0 || stop_cnt !== 1) begin
      n_fail++; $display("FAIL write_stop: got busy %b stops %0d expected 0 1", busy, stop_cnt);
    end
    n_checks++;
    if (wr_addr_q.size() !== 1) begin
      n_fail++; $display("FAIL write_count: got %0d expected 1", wr_addr_q.size());
    end else if (wr_addr_q[0] !== 4'd3 || wr_data_q[0] !== 8'h5A) begin
      n_fail++; $display("FAIL write_value: got %h/%h expected 3/5a", wr_addr_q[0], wr_data_q[0]);
    end
  endtask

  task automatic test_burst_wrap();
    logic [4:0] acks;
    logic [3:0] exp_a [0:2];
    logic [7:0] exp_d [0:2];
    exp_a = '{4'd14, 4'd15, 4'd0};
    exp_d = '{8'h11, 8'h22, 8'h33};
    clear_logs();
    i2c_start();
    write_byte(8'hA0, acks[0]);
    write_byte(8'h0E, acks[1]);
    write_byte(8'h11, acks[2]);
    write_byte(8'h22, acks[3]);
    write_byte(8'h33, acks[4]);
    i2c_stop();
    n_checks++;
    if (acks !== 5'b0) begin n_fail++; $display("FAIL burst_acks: got %b expected 00000", acks); end
    n_checks++;
    if (wr_addr_q.size() !== 3) begin
      n_fail++; $display("FAIL burst_count: got %0d expected 3", wr_addr_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (wr_addr_q[i] !== exp_a[i] || wr_data_q[i] !== exp_d[i]) begin
          n_fail++; $display("FAIL burst_write%0d: got %h/%h expected %h/%h", i, wr_addr_q[i], wr_data_q[i], exp_a[i], exp_d[i]);
        end
      end
    end
  endtask

  task automatic test_read();
    logic a0, a1, a2;
    logic [7:0] b0, b1;
    clear_logs();
    i2c_start();
    write_byte(8'hA0, a0);
    write_byte(8'h07, a1);
    i2c_start();
    write_byte(8'hA1, a2);
    n_checks++;
    if ({a0, a1, a2} !== 3'b000) begin n_fail++; $display("FAIL read_acks: got %b expected 000", {a0, a1, a2}); end
    read_byte(1'b0, b0);
    read_byte(1'b1, b1);
    n_checks++;
    if (b0 !== 8'hC3) begin n_fail++; $display("FAIL read_byte0: got %h expected c3", b0); end
    n_checks++;
    if (b1 !== 8'h3C) begin n_fail++; $display("FAIL read_byte1: got %h expected 3c", b1); end
    n_checks++;
    if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL read_release: got %b expected 0", sda_oe); end
    i2c_stop();
    n_checks++;
    if (rd_addr_q.size() !== 2) begin
      n_fail++; $display("FAIL read_req_count: got %0d expected 2", rd_addr_q.size());
    end else if (rd_addr_q[0] !== 4'd7 || rd_addr_q[1] !== 4'd8) begin
      n_fail++; $display("FAIL read_req_addr: got %h,%h expected 7,8", rd_addr_q[0], rd_addr_q[1]);
    end
    n_checks++;
    if (wr_addr_q.size() !== 0) begin n_fail++; $display("FAIL read_no_write: got %0d expected 0", wr_addr_q.size()); end
  endtask

  task automatic test_addr_mismatch();
    logic a0, a1, a2;
    clear_logs();
    i2c_start();
    write_byte(8'hA2, a0);
    write_byte(8'h01, a1);
    write_byte(8'h99, a2);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL mismatch_busy: got %b expected 1", busy); end
    i2c_stop();
    n_checks++;
    if (oe_cnt !== 0 || {a0, a1, a2} !== 3'b111) begin
      n_fail++; $display("FAIL mismatch_oe: got %0d cycles acks %b expected 0 111", oe_cnt, {a0, a1, a2});
    end
    n_checks++;
    if (wr_addr_q.size() + rd_addr_q.size() !== 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL mismatch_strobes: got %0d busy %b expected 0 0", wr_addr_q.size() + rd_addr_q.size(), busy);
    end
  endtask

  task automatic test_out_of_range();
    logic a0, a1, a2;
    clear_logs();
    i2c_start();
    write_byte(8'hA0, a0);
    write_byte(8'h20, a1);
    write_byte(8'h77, a2);
    i2c_stop();
    n_checks++;
    if ({a0, a1, a2} !== 3'b011) begin n_fail++; $display("FAIL oor_acks: got %b expected 011", {a0, a1, a2}); end
    n_checks++;
    if (wr_addr_q.size() !== 0) begin n_fail++; $display("FAIL oor_write: got %0d expected 0", wr_addr_q.size()); end
  endtask

  task automatic test_reset_mid();
    logic a0, a1;
    clear_logs();
    i2c_start();
    send_bits(8'hA0);
    m_sda = 1'b1; wait_q();
    n_checks++;
    if (sda_oe !== 1'b1) begin n_fail++; $display("FAIL mid_ack_drive: got %b expected 1", sda_oe); end
    reset = 1'b0;
    #1;
    n_checks++;
    if (sda_oe !== 1'b0 || busy !== 1'b0 || reg_addr !== 4'h0) begin
      n_fail++; $display("FAIL mid_reset: got oe %b busy %b addr %h expected 0 0 0", sda_oe, busy, reg_addr);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    wait_q();
    i2c_start();
    write_byte(8'hA0, a0);
    write_byte(8'h05, a1);
    i2c_stop();
    n_checks++;
    if ({a0, a1} !== 2'b00) begin n_fail++; $display("FAIL mid_reacquire: got %b expected 00", {a0, a1}); end
    n_checks++;
    if (wr_addr_q.size() !== 0 || stop_cnt !== 1) begin
      n_fail++; $display("FAIL mid_strobes: got writes %0d stops %0d expected 0 1", wr_addr_q.size(), stop_cnt);
    end
  endtask

  initial begin
    rd_tbl = '{8'hC3, 8'h3C, 8'hFF, 8'hFF};
    test_reset();
    test_write();
    test_burst_wrap();
    test_read();
    test_addr_mismatch();
    test_out_of_range();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_slave_target.md
Name: i2c_slave_target

Overview:
- I2C target (slave) endpoint that answers the transactions issued by the team's I2C master: START, 7-bit address, R/W, ACK, register-address byte, ACK, data byte(s), ACK, STOP.
- Oversamples SCL/SDA on the system clock and drives SDA open-drain (pull-low only).
- Converts bus writes into register-write strobes and bus reads into register-read requests toward a local register bank.
- Sits between the pad ring and a peripheral's control/status registers.

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit bus address this target answers to.
- NUM_REGS, 16, number of 8-bit registers addressable (1..256).
- REG_AW, 4, register pointer width; must satisfy 2**REG_AW >= NUM_REGS.

Ports:
- clk  in  1  system clock; must be >= 8x SCL frequency.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- scl_in  in  1  raw SCL pin level (asynchronous to clk).
- sda_in  in  1  raw SDA pin level (asynchronous to clk).
- sda_oe  out  1  1 = pull SDA low; 0 = release SDA.
- reg_wr_en  out  1  one-cycle write strobe.
- reg_addr  out  REG_AW  register pointer for the current write or read.
- reg_wdata  out  8  write data, valid with reg_wr_en.
- reg_rd_req  out  1  one-cycle read request.
- reg_rdata  in  8  read data; must be valid the cycle after reg_rd_req.
- busy  out  1  high from a detected START until the following STOP.
- stop_det  out  1  one-cycle pulse on a detected STOP.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low. While reset = 0, all of the following hold 0: sda_oe, reg_wr_en, reg_rd_req, busy, stop_det, reg_addr, reg_wdata, and all internal counters and pointers. State = IDLE. Synchronizer flops reset to 1 (bus idle).
- Input conditioning: scl_in and sda_in each pass through a 2-flop synchronizer plus one history flop. An edge is seen 3 clk cycles after the pin toggles.
- START / repeated START: synced SDA 1->0 while synced SCL = 1. From any state: bit counter cleared, sda_oe released, busy = 1, go to ADDR.
- STOP: synced SDA 0->1 while synced SCL = 1. From any state: go to IDLE, busy = 0, stop_det = 1 for one cycle, sda_oe released.
- Data bit timing: sample SDA on SCL rising edge, MSB first. Change sda_oe only on SCL falling edge.
- States:
  - IDLE: wait for START.
  - ADDR: shift in 7 address bits plus R/W. After the 8th rising edge, compare address to SLAVE_ADDR. Match: on the next falling edge go to ADDR_ACK. Mismatch: go to IGNORE with sda_oe = 0.
  - ADDR_ACK: sda_oe = 1 for one SCL period. If R/W = 1, pulse reg_rd_req with reg_addr = pointer in this state, then latch reg_rdata into the TX shifter on the following cycle. On the falling edge ending the ACK: R/W = 0 -> REG; R/W = 1 -> RDATA, driving bit 7.
  - REG: shift in 8 bits. If value < NUM_REGS: load pointer, go to REG_ACK. Otherwise: no ACK, go to IGNORE, pointer unchanged.
  - REG_ACK: drive ACK for one SCL period, then go to WDATA.
  - WDATA: shift in 8 bits. At the 8th rising edge, pulse reg_wr_en with reg_wdata = byte and reg_addr = pointer, then go to WDATA_ACK.
  - WDATA_ACK: drive ACK for one SCL period. Increment pointer; wrap from NUM_REGS-1 to 0. Return to WDATA so multi-byte writes are supported.
  - RDATA: sda_oe = ~tx_bit on each falling edge, 8 bits. Then release SDA and go to RDATA_ACK.
  - RDATA_ACK: sample the master's ACK on the rising edge.
    - ACK (SDA = 0): increment pointer with wrap, pulse reg_rd_req, load the next byte, go to RDATA.
    - NACK: go to IGNORE.
  - IGNORE: sda_oe = 0; only START or STOP leave this state.
- Register pointer: persists across transactions, so write-reg-addr + repeated-START + read works. It is reset only by reset.
- Simultaneous events: START/STOP detection has priority over bit sampling in the same cycle. reg_wr_en is never pulsed for a partial byte interrupted by START/STOP.
- Reset mid-transfer: immediate release of SDA. The bus is re-acquired only at the next START.

Test Plan:
- Write: START, 0xA0, 0x03, 0x5A, STOP -> ACK on all 3 bytes; one reg_wr_en with reg_addr = 3, reg_wdata = 0x5A; stop_det pulses; busy falls.
- Burst write with wrap: START, 0xA0, 0x0E, then 0x11, 0x22, 0x33 -> writes to addresses 14, 15, 0; all bytes ACKed.
- Read: START, 0xA0, 0x07, Sr, 0xA1; bench returns 0xC3 then 0x3C; master ACKs then NACKs -> SDA bits match 0xC3 then 0x3C; reg_rd_req at addresses 7 and 8; SDA released after the NACK.
- Address mismatch: START, 0xA2, ... -> sda_oe stays 0 for the whole transfer; no strobes; busy = 1 until STOP.
- Out-of-range register: START, 0xA0, 0x20 -> NACK on the register byte; following data ignored; no reg_wr_en.
- Reset mid-transfer: drive reset = 0 during the ADDR_ACK low phase -> sda_oe = 0 within the same cycle. After reset = 1, a new START, 0xA0 transaction is ACKed normally.
